// File: rtl/instram_pkg.sv
// Shared types and defaults for the instruction RAM and its streaming loader.
package instram_pkg;

    localparam int ADDR_W_DEF   = 15;
    localparam int DATA_W_DEF   = 8;
    localparam int WR_DELAY_MAX = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } ld_state_t;

endpackage

// File: rtl/instram_core.sv
// Single-write-port memory array with registered read and optional write-to-read forwarding.
module instram_core
    import instram_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int BYPASS = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] wadr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] radr_i,
    output logic [DATA_W-1:0] rdata_o
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Array carries no reset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[wadr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rdata_q <= '0;
        end else if ((BYPASS != 0) && we_i && (wadr_i == radr_i)) begin
            rdata_q <= wdata_i;
        end else begin
            rdata_q <= mem[radr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/instram_loader.sv
// Instruction RAM top: legacy cs/rwn write port with delayed data, plus a
// ready/valid streaming loader that fills a contiguous (wrapping) region.
//
//  state | meaning
//  IDLE  | legacy port owns the write port, waiting for ld_start
//  LOAD  | loader owns the write port, accepting stream words
//  DONE  | one-cycle ld_done pulse, then back to IDLE
module instram_loader
    import instram_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int WR_DELAY = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [15:0]       adr,
    output logic [DATA_W-1:0] data_o,
    input  logic [15:0]       adr_w,
    input  logic              rwn,
    input  logic              cs,
    input  logic [DATA_W-1:0] data_i,
    input  logic              ld_start,
    input  logic [ADDR_W-1:0] ld_base,
    input  logic [ADDR_W:0]   ld_len,
    input  logic              ld_abort,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    output logic              ld_busy,
    output logic              ld_done,
    output logic [DATA_W-1:0] ld_sum,
    output logic              ld_conflict
);

    localparam logic [ADDR_W:0] CNT_LAST = 1;

    ld_state_t         state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0] sum_q, sum_d;
    logic              conflict_q, conflict_d;

    logic [DATA_W-1:0] wr_data_dly;
    logic              legacy_req;
    logic              ld_we;
    logic              lg_we;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_wadr;
    logic [DATA_W-1:0] mem_wdata;

    if (ADDR_W < 16) begin : g_hi_bits
        logic unused_hi;
        assign unused_hi = ^{adr[15:ADDR_W], adr_w[15:ADDR_W]};
    end

    if (WR_DELAY == 0) begin : g_no_dly
        assign wr_data_dly = data_i;
    end else begin : g_dly
        logic [DATA_W-1:0] pipe_q [WR_DELAY];

        always_ff @(posedge clk) begin
            if (!reset_n) begin
                for (int i = 0; i < WR_DELAY; i++) begin
                    pipe_q[i] <= '0;
                end
            end else begin
                pipe_q[0] <= data_i;
                for (int i = 1; i < WR_DELAY; i++) begin
                    pipe_q[i] <= pipe_q[i-1];
                end
            end
        end

        assign wr_data_dly = pipe_q[WR_DELAY-1];
    end

    assign legacy_req = cs && !rwn;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        sum_d      = sum_q;
        conflict_d = conflict_q;
        case (state_q)
            IDLE: begin
                if (ld_start) begin
                    sum_d      = '0;
                    conflict_d = 1'b0;
                    if (ld_len != '0) begin
                        state_d = LOAD;
                        ptr_d   = ld_base;
                        cnt_d   = ld_len;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            LOAD: begin
                if (legacy_req) begin
                    conflict_d = 1'b1;
                end
                // Abort wins over a beat in the same cycle; that word is discarded.
                if (ld_abort) begin
                    state_d = IDLE;
                end else if (ld_valid) begin
                    ptr_d = ptr_q + 1'b1;
                    cnt_d = cnt_q - 1'b1;
                    sum_d = sum_q + ld_data;
                    if (cnt_q == CNT_LAST) begin
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            cnt_q      <= '0;
            sum_q      <= '0;
            conflict_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            sum_q      <= sum_d;
            conflict_q <= conflict_d;
        end
    end

    assign ld_we     = (state_q == LOAD) && ld_valid && !ld_abort;
    assign lg_we     = (state_q != LOAD) && legacy_req;
    assign mem_we    = reset_n && (ld_we || lg_we);
    assign mem_wadr  = ld_we ? ptr_q : adr_w[ADDR_W-1:0];
    assign mem_wdata = ld_we ? ld_data : wr_data_dly;

    instram_core #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .BYPASS (BYPASS)
    ) u_core (
        .clk     (clk),
        .reset_n (reset_n),
        .we_i    (mem_we),
        .wadr_i  (mem_wadr),
        .wdata_i (mem_wdata),
        .radr_i  (adr[ADDR_W-1:0]),
        .rdata_o (data_o)
    );

    assign ld_busy     = (state_q == LOAD);
    assign ld_ready    = (state_q == LOAD);
    assign ld_done     = (state_q == DONE);
    assign ld_sum      = sum_q;
    assign ld_conflict = conflict_q;

endmodule

// File: tb/tb_instram_loader.sv
// Bench for instram_loader: directed scenarios plus random legacy/load traffic,
// checked against an address->byte map of what the memory should hold.
module tb_instram_loader;

    localparam int DEPTH = 32768;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] adr, adr_w;
    logic        rwn, cs;
    logic [7:0]  data_i;
    logic        ld_start, ld_abort, ld_valid;
    logic [14:0] ld_base;
    logic [15:0] ld_len;
    logic [7:0]  ld_data;

    logic [7:0]  data_o, ld_sum;
    logic        ld_ready, ld_busy, ld_done, ld_conflict;
    logic [7:0]  nb_data_o, nb_ld_sum;
    logic        nb_ld_ready, nb_ld_busy, nb_ld_done, nb_ld_conflict;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] mem_m [int];
    int         addrs [$];
    logic [7:0] stream_q [$];
    int         cf_adr;

    always #5 clk = ~clk;

    instram_loader #(.ADDR_W(15), .DATA_W(8), .WR_DELAY(1), .BYPASS(1)) dut (
        .clk(clk), .reset_n(reset_n), .adr(adr), .data_o(data_o), .adr_w(adr_w),
        .rwn(rwn), .cs(cs), .data_i(data_i), .ld_start(ld_start), .ld_base(ld_base),
        .ld_len(ld_len), .ld_abort(ld_abort), .ld_valid(ld_valid), .ld_data(ld_data),
        .ld_ready(ld_ready), .ld_busy(ld_busy), .ld_done(ld_done), .ld_sum(ld_sum),
        .ld_conflict(ld_conflict)
    );

    instram_loader #(.ADDR_W(15), .DATA_W(8), .WR_DELAY(1), .BYPASS(0)) dut_nb (
        .clk(clk), .reset_n(reset_n), .adr(adr), .data_o(nb_data_o), .adr_w(adr_w),
        .rwn(rwn), .cs(cs), .data_i(data_i), .ld_start(ld_start), .ld_base(ld_base),
        .ld_len(ld_len), .ld_abort(ld_abort), .ld_valid(ld_valid), .ld_data(ld_data),
        .ld_ready(nb_ld_ready), .ld_busy(nb_ld_busy), .ld_done(nb_ld_done), .ld_sum(nb_ld_sum),
        .ld_conflict(nb_ld_conflict)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic legacy_write(input int a, input logic [7:0] d, input logic [7:0] junk);
        @(negedge clk);
        data_i = d; cs = 1'b0; rwn = 1'b1;
        @(negedge clk);
        cs = 1'b1; rwn = 1'b0;
        adr_w = {1'($urandom_range(1)), 15'(a)};
        data_i = junk;
        @(negedge clk);
        cs = 1'b0; rwn = 1'b1;
        mem_m[a] = d;
        addrs.push_back(a);
    endtask

    task automatic read_chk(input int a);
        @(negedge clk);
        adr = {1'($urandom_range(1)), 15'(a)};
        @(negedge clk);
        if (mem_m.exists(a)) begin
            check_eq($sformatf("rd[%0h]", a), data_o, mem_m[a]);
            check_eq($sformatf("rd_nb[%0h]", a), nb_data_o, mem_m[a]);
        end
    endtask

    // mode 0: run to completion, 1: abort at beat stop_at, 2: reset at beat stop_at
    task automatic do_load(input int base, input int len, input int mode, input int stop_at,
                           input int cf_at, input int gap_pct);
        logic [7:0] sum_m;
        int i, gaps;
        bit cf_done;
        sum_m = 8'h00; i = 0; gaps = 0; cf_done = 1'b0;
        @(negedge clk);
        ld_start = 1'b1; ld_base = 15'(base); ld_len = 16'(len);
        @(negedge clk);
        ld_start = 1'b0;
        if (len == 0) begin
            check_eq("zl_done", ld_done, 1);
            check_eq("zl_busy", ld_busy, 0);
            check_eq("zl_sum", ld_sum, 0);
            @(negedge clk);
            check_eq("zl_done_clr", ld_done, 0);
            return;
        end
        check_eq("ld_busy_start", ld_busy, 1);
        check_eq("ld_conf_clr", ld_conflict, 0);
        while (i < len) begin
            if (i == cf_at && !cf_done) begin
                cs = 1'b1; rwn = 1'b0; adr_w = 16'(cf_adr); data_i = 8'($urandom);
                cf_done = 1'b1;
            end
            if (mode != 0 && i == stop_at) begin
                if (mode == 1) begin
                    ld_abort = 1'b1; ld_valid = 1'b1; ld_data = 8'hEE;
                    @(negedge clk);
                    ld_abort = 1'b0; ld_valid = 1'b0; cs = 1'b0; rwn = 1'b1;
                    check_eq("ab_busy", ld_busy, 0);
                    check_eq("ab_ready", ld_ready, 0);
                    check_eq("ab_done", ld_done, 0);
                    check_eq("ab_sum", ld_sum, sum_m);
                    @(negedge clk);
                    check_eq("ab_done2", ld_done, 0);
                end else begin
                    reset_n = 1'b0; ld_valid = 1'b0; cs = 1'b0; rwn = 1'b1;
                    @(negedge clk);
                    reset_n = 1'b1;
                    check_eq("rs_data", data_o, 0);
                    check_eq("rs_ready", ld_ready, 0);
                    check_eq("rs_busy", ld_busy, 0);
                    check_eq("rs_done", ld_done, 0);
                    check_eq("rs_sum", ld_sum, 0);
                    check_eq("rs_conflict", ld_conflict, 0);
                    @(negedge clk);
                    check_eq("rs_done2", ld_done, 0);
                end
                return;
            end
            if (gaps < 8 && int'($urandom_range(99)) < gap_pct) begin
                ld_valid = 1'b0; ld_data = 8'($urandom); gaps++;
                @(negedge clk);
                cs = 1'b0; rwn = 1'b1;
                check_eq("ld_busy_gap", ld_busy, 1);
                continue;
            end
            check_eq("ld_ready", ld_ready, 1);
            ld_valid = 1'b1; ld_data = stream_q[i];
            if (i == 1) begin
                ld_start = 1'b1; ld_len = 16'd2; ld_base = 15'($urandom);
            end
            mem_m[(base + i) % DEPTH] = stream_q[i];
            addrs.push_back((base + i) % DEPTH);
            sum_m = sum_m + stream_q[i];
            i++;
            @(negedge clk);
            ld_valid = 1'b0; ld_start = 1'b0; cs = 1'b0; rwn = 1'b1;
        end
        check_eq("end_done", ld_done, 1);
        check_eq("end_busy", ld_busy, 0);
        check_eq("end_ready", ld_ready, 0);
        check_eq("end_sum", ld_sum, sum_m);
        if (cf_at >= 0) check_eq("end_conflict", ld_conflict, 1);
        ld_start = 1'b1; ld_len = 16'd5;
        @(negedge clk);
        ld_start = 1'b0;
        check_eq("post_done", ld_done, 0);
        check_eq("post_busy", ld_busy, 0);
        check_eq("post_sum", ld_sum, sum_m);
    endtask

    task automatic fill_stream(input int len);
        stream_q.delete();
        for (int k = 0; k < len; k++) stream_q.push_back(8'($urandom));
    endtask

    initial begin
        reset_n = 1'b0; adr = '0; adr_w = '0; rwn = 1'b1; cs = 1'b0; data_i = '0;
        ld_start = 1'b0; ld_abort = 1'b0; ld_valid = 1'b0; ld_base = '0; ld_len = '0;
        ld_data = '0; cf_adr = 0;
        @(negedge clk);
        @(negedge clk);
        check_eq("rst_data", data_o, 0);
        check_eq("rst_ready", ld_ready, 0);
        check_eq("rst_busy", ld_busy, 0);
        check_eq("rst_done", ld_done, 0);
        check_eq("rst_sum", ld_sum, 0);
        check_eq("rst_conflict", ld_conflict, 0);
        reset_n = 1'b1;

        legacy_write(16'h0010, 8'hAA, 8'h55);
        read_chk(16'h0010);
        check_eq("legacy_AA", data_o, 8'hAA);

        stream_q = '{8'h01, 8'h02, 8'h03, 8'h04};
        do_load(16'h0100, 4, 0, 0, -1, 40);
        check_eq("sum_0A", ld_sum, 8'h0A);
        for (int k = 0; k < 4; k++) read_chk(16'h0100 + k);

        stream_q = '{8'h11, 8'h22, 8'h33};
        do_load(16'h7FFE, 3, 0, 0, -1, 0);
        read_chk(16'h7FFE);
        read_chk(16'h7FFF);
        read_chk(0);
        check_eq("wrap_0", data_o, 8'h33);

        legacy_write(16'h0203, 8'h99, 8'h00);
        fill_stream(8);
        do_load(16'h0200, 8, 1, 3, -1, 30);
        for (int k = 0; k < 4; k++) read_chk(16'h0200 + k);

        legacy_write(16'h0303, 8'h77, 8'h12);
        legacy_write(16'h0400, 8'h44, 8'h34);
        cf_adr = 16'h0400;
        fill_stream(8);
        do_load(16'h0300, 8, 2, 3, 1, 30);
        for (int k = 0; k < 4; k++) read_chk(16'h0300 + k);
        read_chk(16'h0400);

        legacy_write(16'h0410, 8'h3C, 8'hC3);
        cf_adr = 16'h0410;
        fill_stream(4);
        do_load(16'h0500, 4, 0, 0, 2, 20);
        read_chk(16'h0410);

        do_load(16'h0600, 0, 0, 0, -1, 0);

        legacy_write(16'h0020, 8'h33, 8'h00);
        @(negedge clk);
        data_i = 8'h5A;
        @(negedge clk);
        cs = 1'b1; rwn = 1'b0; adr_w = 16'h0020; adr = 16'h0020; data_i = 8'h00;
        @(negedge clk);
        cs = 1'b0; rwn = 1'b1;
        check_eq("bypass_on", data_o, 8'h5A);
        check_eq("bypass_off", nb_data_o, 8'h33);
        mem_m[16'h0020] = 8'h5A;
        read_chk(16'h0020);

        for (int it = 0; it < 30; it++) begin
            case ($urandom_range(3))
                0: legacy_write(int'($urandom_range(DEPTH - 1)), 8'($urandom), 8'($urandom));
                1: begin
                    int base, len, mode, stop;
                    base = ($urandom_range(3) == 0) ? 32'h7FFC + int'($urandom_range(3))
                                                    : int'($urandom_range(DEPTH - 1));
                    len  = int'($urandom_range(6, 1));
                    mode = ($urandom_range(3) == 0) ? 1 : 0;
                    stop = int'($urandom_range(len - 1));
                    fill_stream(len);
                    do_load(base, len, mode, stop, -1, 30);
                end
                2: begin
                    @(negedge clk);
                    cs = 1'b1; rwn = 1'b1; data_i = 8'($urandom);
                    adr_w = 16'(addrs[$urandom_range(addrs.size() - 1)]);
                    @(negedge clk);
                    cs = 1'b0;
                end
                default: begin
                    for (int k = 0; k < 3; k++) read_chk(addrs[$urandom_range(addrs.size() - 1)]);
                end
            endcase
        end
        foreach (addrs[k]) read_chk(addrs[k]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
